// File: rtl/ma_dphase_pkg.sv
// Shared encodings for the memory-access data-phase block: access sizes and FSM states.
package p_hardisc;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ERR  = 2'b10
  } dphase_state_t;

endpackage

// File: rtl/ma_dphase_if.sv
// EXMA/MAWB pipeline and AHB data-phase signals of the MA stage, grouped as one bundle.
interface ma_dphase_if;

  logic        s_flush_i;
  logic        s_exma_valid_i;
  logic        s_exma_lsu_i;
  logic        s_exma_approved_i;
  logic        s_exma_write_i;
  logic [1:0]  s_exma_size_i;
  logic        s_exma_unsigned_i;
  logic [4:0]  s_exma_rd_i;
  logic [31:0] s_exma_val_i;
  logic        s_d_hready_i;
  logic        s_d_hresp_i;
  logic [31:0] s_d_hrdata_i;
  logic        s_stall_o;
  logic [31:0] s_mawb_val_o;
  logic [4:0]  s_mawb_rd_o;
  logic        s_mawb_we_o;
  logic        s_mawb_berr_o;

  modport slave (
    input  s_flush_i, s_exma_valid_i, s_exma_lsu_i, s_exma_approved_i, s_exma_write_i,
    input  s_exma_size_i, s_exma_unsigned_i, s_exma_rd_i, s_exma_val_i,
    input  s_d_hready_i, s_d_hresp_i, s_d_hrdata_i,
    output s_stall_o, s_mawb_val_o, s_mawb_rd_o, s_mawb_we_o, s_mawb_berr_o
  );

  modport master (
    output s_flush_i, s_exma_valid_i, s_exma_lsu_i, s_exma_approved_i, s_exma_write_i,
    output s_exma_size_i, s_exma_unsigned_i, s_exma_rd_i, s_exma_val_i,
    output s_d_hready_i, s_d_hresp_i, s_d_hrdata_i,
    input  s_stall_o, s_mawb_val_o, s_mawb_rd_o, s_mawb_we_o, s_mawb_berr_o
  );

endinterface

// File: rtl/ma_load_align.sv
// Aligns raw HRDATA to the addressed byte lane and extends it to 32 bits per access size.
module ma_load_align
  import p_hardisc::*;
(
  input  logic [31:0] hrdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [31:0] shifted_s;
  logic        sign_b_s;
  logic        sign_h_s;

  assign shifted_s = hrdata >> {addr_lo, 3'b000};
  assign sign_b_s  = !uns && shifted_s[7];
  assign sign_h_s  = !uns && shifted_s[15];

  // Size select; the illegal encoding behaves as a word access.
  always_comb begin
    data = shifted_s;
    case (size)
      SIZE_B:  data = {{24{sign_b_s}}, shifted_s[7:0]};
      SIZE_H:  data = {{16{sign_h_s}}, shifted_s[15:0]};
      SIZE_W:  data = shifted_s;
      default: data = shifted_s;
    endcase
  end

endmodule

// File: rtl/ma_dphase.sv
// MA-stage AHB3-Lite data phase: waits for HREADY, handles bus errors and an optional
// watchdog, and produces the registered MAWB writeback.
module ma_dphase
  import p_hardisc::*;
#(
  parameter int unsigned TIMEOUT = 0
) (
  input logic        s_clk_i,
  input logic        s_reset_i,
  ma_dphase_if.slave bus
);

  localparam bit         WDOG_EN    = (TIMEOUT != 32'd0);
  localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 32'd1);

  dphase_state_t state_r, state_s;
  logic [7:0]    cnt_r;
  logic          flushed_r;
  logic [31:0]   val_r, val_s;
  logic [4:0]    rd_r, rd_s;
  logic          we_r, we_s;
  logic          berr_r, berr_s;

  logic        lsu_acc_s, active_s, expire_s, done_s, err_wb_s, kill_s;
  logic [31:0] load_data_s;

  assign lsu_acc_s = bus.s_exma_valid_i && bus.s_exma_lsu_i && bus.s_exma_approved_i;
  assign active_s  = (state_r == WAIT) || ((state_r == IDLE) && lsu_acc_s);
  assign expire_s  = WDOG_EN && (state_r == WAIT) && (cnt_r == TIMEOUT_M1)
                     && !bus.s_d_hready_i && !bus.s_d_hresp_i;
  assign done_s    = active_s && bus.s_d_hready_i;
  assign err_wb_s  = (done_s && bus.s_d_hresp_i) || (state_r == ERR) || expire_s;
  // A flush seen at any point of a pending transfer squashes its eventual writeback.
  assign kill_s    = bus.s_flush_i || flushed_r;

  // Expiry releases the stall so the timed-out instruction leaves MA instead of reissuing.
  assign bus.s_stall_o = !s_reset_i &&
                         ((active_s && !bus.s_d_hready_i && !expire_s) ||
                          ((state_r == ERR) && !bus.s_d_hready_i));

  ma_load_align u_align (
    .hrdata  (bus.s_d_hrdata_i),
    .addr_lo (bus.s_exma_val_i[1:0]),
    .size    (bus.s_exma_size_i),
    .uns     (bus.s_exma_unsigned_i),
    .data    (load_data_s)
  );

  // Next-state logic of the data-phase FSM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (lsu_acc_s && !bus.s_d_hready_i) begin
          state_s = bus.s_d_hresp_i ? ERR : WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (bus.s_d_hresp_i && !bus.s_d_hready_i) begin
          state_s = ERR;
        end else if (bus.s_d_hready_i || expire_s) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      ERR:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Writeback selection: single-cycle result, error/timeout report, load/store completion, or bubble.
  always_comb begin
    val_s  = val_r;
    rd_s   = rd_r;
    we_s   = 1'b0;
    berr_s = 1'b0;
    if ((state_r == IDLE) && bus.s_exma_valid_i && !lsu_acc_s) begin
      val_s = bus.s_exma_val_i;
      rd_s  = bus.s_exma_rd_i;
      we_s  = (bus.s_exma_rd_i != 5'd0) && !kill_s;
    end else if (err_wb_s) begin
      val_s  = bus.s_exma_val_i;
      rd_s   = bus.s_exma_rd_i;
      berr_s = !kill_s;
    end else if (done_s) begin
      rd_s = bus.s_exma_rd_i;
      if (bus.s_exma_write_i) begin
        val_s = bus.s_exma_val_i;
      end else begin
        val_s = load_data_s;
        we_s  = (bus.s_exma_rd_i != 5'd0) && !kill_s;
      end
    end else begin
      val_s = val_r;
    end
  end

  // FSM state, watchdog counter and sticky flush flag.
  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      state_r   <= IDLE;
      cnt_r     <= 8'd0;
      flushed_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      flushed_r <= (state_s != IDLE) ? kill_s : 1'b0;
      if ((state_r != WAIT) && (state_s == WAIT)) begin
        cnt_r <= 8'd0;
      end else if (state_r == WAIT) begin
        cnt_r <= cnt_r + 8'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // MAWB pipeline register.
  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      val_r  <= 32'd0;
      rd_r   <= 5'd0;
      we_r   <= 1'b0;
      berr_r <= 1'b0;
    end else begin
      val_r  <= val_s;
      rd_r   <= rd_s;
      we_r   <= we_s;
      berr_r <= berr_s;
    end
  end

  assign bus.s_mawb_val_o  = val_r;
  assign bus.s_mawb_rd_o   = rd_r;
  assign bus.s_mawb_we_o   = we_r;
  assign bus.s_mawb_berr_o = berr_r;

endmodule

// File: tb/tb_ma_dphase.sv
// Self-checking bench for ma_dphase (watchdog TIMEOUT = 4): directed cases plus random
// transactions checked against a transaction-level reference model.
module tb_ma_dphase;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  ma_dphase_if bus_if ();

  ma_dphase #(.TIMEOUT(TO)) dut (
    .s_clk_i   (clk),
    .s_reset_i (rst),
    .bus       (bus_if.slave)
  );

  always #5 clk = ~clk;

  // Reference load result derived from byte-lane arithmetic.
  function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [1:0] off,
                                           input logic [1:0] sz, input logic uns);
    int          nbytes;
    logic [31:0] s, mask, v;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    s = d >> (8 * int'(off));
    if (nbytes == 4) return s;
    mask = (32'd1 << (8 * nbytes)) - 32'd1;
    v = s & mask;
    if (!uns && v[8 * nbytes - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic drive_idle();
    bus_if.s_flush_i         = 1'b0;
    bus_if.s_exma_valid_i    = 1'b0;
    bus_if.s_exma_lsu_i      = 1'b0;
    bus_if.s_exma_approved_i = 1'b0;
    bus_if.s_exma_write_i    = 1'b0;
    bus_if.s_exma_size_i     = 2'd0;
    bus_if.s_exma_unsigned_i = 1'b0;
    bus_if.s_exma_rd_i       = 5'd0;
    bus_if.s_exma_val_i      = 32'd0;
    bus_if.s_d_hready_i      = 1'b1;
    bus_if.s_d_hresp_i       = 1'b0;
    bus_if.s_d_hrdata_i      = 32'd0;
  endtask

  // Holds one instruction in EXMA until stall drops; hready is low for the first nlow cycles.
  task automatic do_txn(input logic lsu, input logic appr, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [4:0] rd, input logic [31:0] addr,
                        input logic [31:0] hrd, input int nlow, input logic err,
                        input int flush_at, output int stalls, output logic done);
    logic st;
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus_if.s_exma_valid_i    = 1'b1;
      bus_if.s_exma_lsu_i      = lsu;
      bus_if.s_exma_approved_i = appr;
      bus_if.s_exma_write_i    = wr;
      bus_if.s_exma_size_i     = sz;
      bus_if.s_exma_unsigned_i = uns;
      bus_if.s_exma_rd_i       = rd;
      bus_if.s_exma_val_i      = addr;
      bus_if.s_d_hready_i      = (c >= nlow);
      bus_if.s_d_hresp_i       = err && (c >= nlow - 1);
      bus_if.s_d_hrdata_i      = (c >= nlow) ? hrd : $urandom;
      bus_if.s_flush_i         = (c == flush_at);
      #1;
      st = bus_if.s_stall_o;
      if (st) stalls++;
      @(posedge clk);
      #1;
      if (!st) begin
        done = 1'b1;
        break;
      end
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    drive_idle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    drive_idle();
    bus_if.s_exma_valid_i = 1'b1; bus_if.s_exma_lsu_i = 1'b1; bus_if.s_exma_approved_i = 1'b1;
    bus_if.s_d_hready_i = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus_if.s_stall_o !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", bus_if.s_stall_o); end
    @(posedge clk); #1;
    n_cmp++; if ({bus_if.s_mawb_val_o, bus_if.s_mawb_rd_o, bus_if.s_mawb_we_o, bus_if.s_mawb_berr_o} !== 39'd0) begin
      n_fail++; $display("FAIL rst_regs: got val=%h rd=%0d we=%b berr=%b want all 0", bus_if.s_mawb_val_o,
                         bus_if.s_mawb_rd_o, bus_if.s_mawb_we_o, bus_if.s_mawb_berr_o); end
    @(negedge clk);
    drive_idle();
    rst = 1'b0;
  endtask

  task automatic test_lw();
    int st; logic dn;
    do_txn(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 5'd5, 32'h100, 32'h8899AABB, 0, 1'b0, -1, st, dn);
    n_cmp++; if (st !== 0) begin n_fail++; $display("FAIL lw_stall: got %0d want 0", st); end
    n_cmp++; if (bus_if.s_mawb_val_o !== 32'h8899AABB) begin n_fail++; $display("FAIL lw_val: got %h want 8899aabb", bus_if.s_mawb_val_o); end
    n_cmp++; if (bus_if.s_mawb_we_o !== 1'b1 || bus_if.s_mawb_rd_o !== 5'd5) begin n_fail++; $display("FAIL lw_we: got we=%b rd=%0d want 1/5", bus_if.s_mawb_we_o, bus_if.s_mawb_rd_o); end
  endtask

  task automatic test_lb_lhu();
    int st; logic dn;
    do_txn(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 5'd3, 32'h103, 32'h80112233, 0, 1'b0, -1, st, dn);
    n_cmp++; if (bus_if.s_mawb_val_o !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_val: got %h want ffffff80", bus_if.s_mawb_val_o); end
    do_txn(1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 5'd4, 32'h102, 32'h80112233, 0, 1'b0, -1, st, dn);
    n_cmp++; if (bus_if.s_mawb_val_o !== 32'h00008011) begin n_fail++; $display("FAIL lhu_val: got %h want 00008011", bus_if.s_mawb_val_o); end
  endtask

  task automatic test_wait();
    int st; logic dn;
    do_txn(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 5'd9, 32'h140, 32'h13572468, 3, 1'b0, -1, st, dn);
    n_cmp++; if (st !== 3 || !dn) begin n_fail++; $display("FAIL wait_stall: got %0d done=%b want 3", st, dn); end
    n_cmp++; if (bus_if.s_mawb_val_o !== 32'h13572468 || bus_if.s_mawb_we_o !== 1'b1) begin
      n_fail++; $display("FAIL wait_wb: got val=%h we=%b want 13572468/1", bus_if.s_mawb_val_o, bus_if.s_mawb_we_o); end
  endtask

  task automatic test_error();
    int st; logic dn;
    do_txn(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 5'd6, 32'h200, 32'h0, 1, 1'b1, -1, st, dn);
    n_cmp++; if (st !== 1) begin n_fail++; $display("FAIL err_stall: got %0d want 1", st); end
    n_cmp++; if (bus_if.s_mawb_berr_o !== 1'b1 || bus_if.s_mawb_we_o !== 1'b0 || bus_if.s_mawb_val_o !== 32'h200) begin
      n_fail++; $display("FAIL err_wb: got berr=%b we=%b val=%h want 1/0/200", bus_if.s_mawb_berr_o, bus_if.s_mawb_we_o, bus_if.s_mawb_val_o); end
    idle_cycle();
    n_cmp++; if (bus_if.s_mawb_berr_o !== 1'b0) begin n_fail++; $display("FAIL err_pulse: got berr=%b want 0", bus_if.s_mawb_berr_o); end
    do_txn(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 5'd6, 32'h204, 32'h0, 0, 1'b1, -1, st, dn);
    n_cmp++; if (st !== 0 || bus_if.s_mawb_berr_o !== 1'b1 || bus_if.s_mawb_we_o !== 1'b0) begin
      n_fail++; $display("FAIL err_first: got stall=%0d berr=%b we=%b want 0/1/0", st, bus_if.s_mawb_berr_o, bus_if.s_mawb_we_o); end
  endtask

  task automatic test_timeout();
    int st; logic dn;
    do_txn(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 5'd8, 32'h300, 32'h0, 15, 1'b0, -1, st, dn);
    n_cmp++; if (st !== TO || !dn) begin n_fail++; $display("FAIL wdog_stall: got %0d done=%b want %0d", st, dn, TO); end
    n_cmp++; if (bus_if.s_mawb_berr_o !== 1'b1 || bus_if.s_mawb_we_o !== 1'b0 || bus_if.s_mawb_val_o !== 32'h300) begin
      n_fail++; $display("FAIL wdog_wb: got berr=%b we=%b val=%h want 1/0/300", bus_if.s_mawb_berr_o, bus_if.s_mawb_we_o, bus_if.s_mawb_val_o); end
  endtask

  task automatic test_flush();
    int st; logic dn;
    do_txn(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 5'd10, 32'h400, 32'hDEADBEEF, 3, 1'b0, 2, st, dn);
    n_cmp++; if (st !== 3) begin n_fail++; $display("FAIL flush_stall: got %0d want 3", st); end
    n_cmp++; if (bus_if.s_mawb_we_o !== 1'b0 || bus_if.s_mawb_berr_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_we: got we=%b berr=%b want 0/0", bus_if.s_mawb_we_o, bus_if.s_mawb_berr_o); end
  endtask

  task automatic test_nonlsu_idle();
    int st; logic dn;
    do_txn(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd7, 32'h12345678, 32'h0, 2, 1'b0, -1, st, dn);
    n_cmp++; if (st !== 0 || bus_if.s_mawb_we_o !== 1'b1 || bus_if.s_mawb_val_o !== 32'h12345678) begin
      n_fail++; $display("FAIL alu_wb: got stall=%0d we=%b val=%h want 0/1/12345678", st, bus_if.s_mawb_we_o, bus_if.s_mawb_val_o); end
    do_txn(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 5'd0, 32'hCAFEF00D, 32'h0, 2, 1'b0, -1, st, dn);
    n_cmp++; if (st !== 0 || bus_if.s_mawb_we_o !== 1'b0 || bus_if.s_mawb_val_o !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL unappr_wb: got stall=%0d we=%b val=%h want 0/0/cafef00d", st, bus_if.s_mawb_we_o, bus_if.s_mawb_val_o); end
    idle_cycle();
    idle_cycle();
    n_cmp++; if (bus_if.s_mawb_we_o !== 1'b0 || bus_if.s_mawb_val_o !== 32'hCAFEF00D || bus_if.s_mawb_rd_o !== 5'd0) begin
      n_fail++; $display("FAIL idle_hold: got we=%b val=%h rd=%0d want 0/cafef00d/0", bus_if.s_mawb_we_o, bus_if.s_mawb_val_o, bus_if.s_mawb_rd_o); end
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    bus_if.s_exma_valid_i = 1'b1; bus_if.s_exma_lsu_i = 1'b1; bus_if.s_exma_approved_i = 1'b1;
    bus_if.s_exma_rd_i = 5'd12; bus_if.s_exma_val_i = 32'h500; bus_if.s_d_hready_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (bus_if.s_stall_o !== 1'b0 || bus_if.s_mawb_we_o !== 1'b0) begin
      n_fail++; $display("FAIL rstwait_stall: got stall=%b we=%b want 0/0", bus_if.s_stall_o, bus_if.s_mawb_we_o); end
    @(negedge clk);
    drive_idle();
    rst = 1'b0;
    bus_if.s_d_hready_i = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus_if.s_mawb_we_o !== 1'b0 || bus_if.s_mawb_berr_o !== 1'b0) begin
      n_fail++; $display("FAIL rstwait_wb: got we=%b berr=%b want 0/0", bus_if.s_mawb_we_o, bus_if.s_mawb_berr_o); end
  endtask

  task automatic test_random();
    int st, nlow, fa, es;
    logic dn, lsu, appr, wr, uns, err, fl, ewe, eberr, vchk;
    logic [1:0] sz; logic [4:0] rd; logic [31:0] addr, hrd, ev;
    for (int i = 0; i < 250; i++) begin
      lsu = ($urandom % 4) != 0; appr = ($urandom % 5) != 0; wr = $urandom % 3 == 0;
      sz = 2'($urandom); uns = 1'($urandom); rd = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
      addr = $urandom; hrd = $urandom; err = ($urandom % 4) == 0;
      nlow = err ? int'($urandom % 5) : int'($urandom % 8);
      fa = ($urandom % 4 == 0) ? int'($urandom % (nlow + 1)) : -1;
      vchk = 1'b1; ev = addr; ewe = 1'b0; eberr = 1'b0;
      if (!(lsu && appr)) begin
        es = 0; fl = (fa == 0); ewe = (rd != 5'd0) && !fl;
      end else if (err) begin
        es = nlow; fl = (fa >= 0); eberr = !fl;
      end else if (nlow >= TO + 1) begin
        es = TO; fl = (fa >= 0) && (fa <= TO); eberr = !fl;
      end else begin
        es = nlow; fl = (fa >= 0);
        if (wr) vchk = 1'b0;
        else begin ev = ref_load(hrd, addr[1:0], sz, uns); ewe = (rd != 5'd0) && !fl; end
      end
      do_txn(lsu, appr, wr, sz, uns, rd, addr, hrd, nlow, err, fa, st, dn);
      n_cmp++; if (st !== es || !dn) begin n_fail++; $display("FAIL rnd_stall[%0d]: got %0d done=%b want %0d", i, st, dn, es); end
      n_cmp++; if (bus_if.s_mawb_we_o !== ewe || bus_if.s_mawb_berr_o !== eberr || bus_if.s_mawb_rd_o !== rd) begin
        n_fail++; $display("FAIL rnd_ctl[%0d]: got we=%b berr=%b rd=%0d want %b/%b/%0d", i, bus_if.s_mawb_we_o,
                           bus_if.s_mawb_berr_o, bus_if.s_mawb_rd_o, ewe, eberr, rd); end
      if (vchk) begin
        n_cmp++; if (bus_if.s_mawb_val_o !== ev) begin n_fail++; $display("FAIL rnd_val[%0d]: got %h want %h", i, bus_if.s_mawb_val_o, ev); end
      end
      if ($urandom % 3 == 0) begin
        idle_cycle();
        n_cmp++; if (bus_if.s_mawb_we_o !== 1'b0 || bus_if.s_mawb_berr_o !== 1'b0 || (vchk && bus_if.s_mawb_val_o !== ev)) begin
          n_fail++; $display("FAIL rnd_idle[%0d]: got we=%b berr=%b val=%h want 0/0/%h", i, bus_if.s_mawb_we_o,
                             bus_if.s_mawb_berr_o, bus_if.s_mawb_val_o, ev); end
      end
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_lw();
    test_lb_lhu();
    test_wait();
    test_error();
    test_timeout();
    test_flush();
    test_nonlsu_idle();
    test_reset_in_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ma_dphase.md
MA_DPHASE -- requirements
Module: ma_dphase

Interface
REQ-001 Parameter TIMEOUT, default 0, sets the data-phase watchdog limit in cycles; 0 disables the watchdog; legal range 0..255.
REQ-002 s_clk_i  in  1  single clock; all state updates on its rising edge.
REQ-003 s_reset_i  in  1  asynchronous, active-high reset.
REQ-004 s_flush_i  in  1  squashes the instruction currently in MA.
REQ-005 s_exma_valid_i  in  1  EXMA register holds an instruction.
REQ-006 s_exma_lsu_i  in  1  instruction is a load/store.
REQ-007 s_exma_approved_i  in  1  address phase was issued by EX for this instruction.
REQ-008 s_exma_write_i  in  1  store (1) / load (0).
REQ-009 s_exma_size_i  in  2  00 byte, 01 half, 10 word; 11 is illegal and treated as word.
REQ-010 s_exma_unsigned_i  in  1  zero-extend (1) / sign-extend (0) loads.
REQ-011 s_exma_rd_i  in  5  destination register.
REQ-012 s_exma_val_i  in  32  EX result (non-LSU) or access address.
REQ-013 s_d_hready_i  in  1  AHB3-Lite HREADY.
REQ-014 s_d_hresp_i  in  1  AHB3-Lite HRESP (1 = ERROR).
REQ-015 s_d_hrdata_i  in  32  AHB3-Lite HRDATA.
REQ-016 s_stall_o  out  1  holds upstream stages; combinational.
REQ-017 s_mawb_val_o  out  32  registered writeback value.
REQ-018 s_mawb_rd_o  out  5  registered destination register.
REQ-019 s_mawb_we_o  out  1  registered register-file write enable.
REQ-020 s_mawb_berr_o  out  1  registered one-cycle bus-error/timeout flag.

Function
REQ-021 State machine SHALL have states IDLE, WAIT, and ERR.
- IDLE to WAIT: valid & lsu & approved & !hready & !hresp.
- IDLE or WAIT to ERR: hresp & !hready.
- ERR to IDLE: next cycle, regardless of hready.
- WAIT to IDLE: hready & !hresp.
- WAIT to IDLE: watchdog expiry.
REQ-022 A data phase is active when the state is WAIT, or when the state is IDLE and valid & lsu & approved.
REQ-023 s_stall_o SHALL equal (data phase active & !hready) | (state == ERR & !hready).
REQ-024 Completion cycle SHALL be any cycle in which a data phase is active and hready = 1; MAWB registers SHALL update on that edge (latency 1 cycle after completion).
REQ-025 Load data: HRDATA SHALL be shifted right by 8*val[1:0], then masked to the access size and sign- or zero-extended per s_exma_unsigned_i.
REQ-026 Load completion without error SHALL give we = (rd != 0) and val = aligned data.
REQ-027 Store completion SHALL give we = 0.
REQ-028 Valid non-LSU, or LSU with approved = 0, SHALL complete in 1 cycle: val = s_exma_val_i, we = (rd != 0), stall = 0.
REQ-029 ERR exit, or watchdog expiry, SHALL set berr = 1, we = 0, and val = access address for one cycle.
REQ-030 Watchdog: an 8-bit counter SHALL clear on entry to WAIT and increment each WAIT cycle; expiry occurs when count == TIMEOUT-1 and TIMEOUT != 0.
REQ-031 Flush in any state SHALL force we = 0 and berr = 0 for the squashed instruction.
REQ-032 Flush SHALL NOT abort a pending data phase; the FSM still waits for hready, and stall stays asserted per REQ-023.
REQ-033 Idle cycles (valid = 0, no data phase pending) SHALL write we = 0 and berr = 0 and hold val/rd.
REQ-034 Simultaneous hresp & hready in the first data-phase cycle SHALL be treated as error completion with berr = 1.

Reset
REQ-035 On s_reset_i: state IDLE, counter 0, s_mawb_val_o 0, s_mawb_rd_o 0, s_mawb_we_o 0, s_mawb_berr_o 0.
REQ-036 Reset asserted in WAIT or ERR SHALL abandon the transfer immediately with no writeback.
REQ-037 s_stall_o SHALL be 0 while reset is asserted.

Structure
REQ-038 Size encodings (SIZE_B, SIZE_H, SIZE_W) and the FSM state enum SHALL reside in p_hardisc.
REQ-039 Load alignment and extension SHALL be a combinational sub-module ma_load_align (hrdata, addr_lo, size, unsigned -> 32-bit data).
REQ-040 The block SHALL be non-replicated; the parent replicates it if required.

Verification
REQ-041 LW at address 0x100, hrdata 0x8899AABB, hready = 1 -> next cycle val = 0x8899AABB, we = 1, stall never asserted.
REQ-042 LB signed at address 0x103, hrdata 0x80112233 -> val = 0xFFFFFF80.
REQ-043 LHU at address 0x102, hrdata 0x80112233 -> val = 0x00008011.
REQ-044 LW with hready low for 3 cycles -> stall high for exactly 3 cycles; writeback on the 4th edge.
REQ-045 AHB error: hresp = 1/hready = 0, then hresp = 1/hready = 1 -> stall for 1 cycle, then berr = 1, we = 0, val = address.
REQ-046 TIMEOUT = 4 with hready held low -> stall for 4 cycles, then berr = 1.
REQ-047 Flush asserted during WAIT -> we = 0 on completion.
